// File: rtl/cpu_regs_param.sv
// Parametrised register file, program counter, flags and hardware return stack
// for the nic8-family CPU datapath. All outputs are registered.
module cpu_regs_param #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NREGS   = 4,
   parameter int unsigned RSDEPTH = 4
) (
   input  logic                             clk,
   input  logic                             resetB,
   input  logic [WIDTH-1:0]                 dbus,
   input  logic                             loadIR,
   input  logic                             loadReg,
   input  logic [$clog2(NREGS)-1:0]         loadSel,
   input  logic                             incPC,
   input  logic                             loadPC,
   input  logic [1:0]                       jumpCond,
   input  logic                             call,
   input  logic                             ret,
   input  logic                             assertE,
   input  logic                             carry,
   input  logic                             aluZero,
   output logic [WIDTH-1:0]                 ir,
   output logic [WIDTH-1:0]                 pc,
   output logic [NREGS*WIDTH-1:0]           regs,
   output logic                             flagCarry,
   output logic                             flagZero,
   output logic [$clog2(RSDEPTH+1)-1:0]     rsCount,
   output logic                             rsFault
);

   localparam int unsigned SELW = $clog2(NREGS);
   localparam int unsigned CNTW = $clog2(RSDEPTH + 1);
   localparam int unsigned IDXW = (RSDEPTH > 1) ? $clog2(RSDEPTH) : 1;
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(RSDEPTH);

   logic [WIDTH-1:0] reg_q [NREGS];
   logic [WIDTH-1:0] stack [RSDEPTH];

   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_next;
   logic [CNTW-1:0]  cnt_next;
   logic             fault_next;
   logic             cond_ok;
   logic             jump_taken;
   logic             push;
   logic [IDXW-1:0]  push_idx;
   logic [IDXW-1:0]  pop_idx;

   assign pc_inc   = pc + WIDTH'(1);
   assign push_idx = IDXW'(rsCount);
   assign pop_idx  = IDXW'(rsCount - CNTW'(1));

   // Condition uses the flags as they stand before this edge.
   always_comb begin
      cond_ok = 1'b1;
      unique case (jumpCond)
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = flagCarry;
         2'b10:   cond_ok = flagZero;
         2'b11:   cond_ok = ~flagCarry;
         default: cond_ok = 1'b1;
      endcase
   end

   assign jump_taken = loadPC & cond_ok;

   always_comb begin
      pc_next    = pc;
      cnt_next   = rsCount;
      fault_next = rsFault;
      push       = 1'b0;
      if (call && ret) begin
         fault_next = 1'b1;
      end else if (ret) begin
         if (rsCount != '0) begin
            pc_next  = stack[pop_idx];
            cnt_next = rsCount - CNTW'(1);
         end else begin
            fault_next = 1'b1;
         end
      end else if (call) begin
         pc_next = dbus;
         if (rsCount != DEPTH_C) begin
            push     = 1'b1;
            cnt_next = rsCount + CNTW'(1);
         end else begin
            fault_next = 1'b1;
         end
      end else if (jump_taken) begin
         pc_next = dbus;
      end else if (incPC) begin
         pc_next = pc_inc;
      end
   end

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         ir        <= '0;
         pc        <= '0;
         flagCarry <= 1'b0;
         flagZero  <= 1'b0;
         rsCount   <= '0;
         rsFault   <= 1'b0;
      end else begin
         ir      <= loadIR ? dbus : '0;
         pc      <= pc_next;
         rsCount <= cnt_next;
         rsFault <= fault_next;
         if (assertE) begin
            flagCarry <= carry;
            flagZero  <= aluZero;
         end
      end
   end

   // Decoding by equality leaves out-of-range indices as silent no-ops.
   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         for (int unsigned i = 0; i < NREGS; i++) reg_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (loadReg && (loadSel == SELW'(i))) reg_q[i] <= dbus;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) stack[push_idx] <= pc_inc;
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_regs
      assign regs[g*WIDTH +: WIDTH] = reg_q[g];
   end

endmodule

// File: tb/tb_cpu_regs_param.sv
// Directed bench for cpu_regs_param (WIDTH=8, NREGS=4, RSDEPTH=4): reset, register
// file, conditional jumps, PC wrap, return stack and call/ret conflict.
module tb_cpu_regs_param;

   logic        clk = 1'b0;
   logic        resetB;
   logic [7:0]  dbus;
   logic        loadIR, loadReg, incPC, loadPC, call, ret, assertE, carry, aluZero;
   logic [1:0]  loadSel, jumpCond;
   logic [7:0]  ir, pc;
   logic [31:0] regs;
   logic        flagCarry, flagZero, rsFault;
   logic [2:0]  rsCount;

   int vectors = 0;
   int miscompares = 0;

   cpu_regs_param #(.WIDTH(8), .NREGS(4), .RSDEPTH(4)) dut (
      .clk(clk), .resetB(resetB), .dbus(dbus), .loadIR(loadIR), .loadReg(loadReg),
      .loadSel(loadSel), .incPC(incPC), .loadPC(loadPC), .jumpCond(jumpCond),
      .call(call), .ret(ret), .assertE(assertE), .carry(carry), .aluZero(aluZero),
      .ir(ir), .pc(pc), .regs(regs), .flagCarry(flagCarry), .flagZero(flagZero),
      .rsCount(rsCount), .rsFault(rsFault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      dbus = 8'h00; loadIR = 0; loadReg = 0; loadSel = 2'd0; incPC = 0; loadPC = 0;
      jumpCond = 2'b00; call = 0; ret = 0; assertE = 0; carry = 0; aluZero = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_reset();
      idle();
      resetB = 1'b0;
      #3;
      vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc got=%h exp=00", pc); end
      vectors++; if (regs !== 32'h0) begin miscompares++; $display("FAIL rst_regs got=%h exp=0", regs); end
      vectors++; if (rsCount !== 3'd0 || rsFault !== 1'b0) begin miscompares++; $display("FAIL rst_rs got=%0d/%b exp=0/0", rsCount, rsFault); end
      @(negedge clk);
      resetB = 1'b1;
   endtask

   task automatic test_regs();
      for (int i = 0; i < 4; i++) begin
         loadReg = 1; loadSel = 2'(i); dbus = 8'(8'h11 * (i + 1));
         tick();
         vectors++; if (ir !== 8'h00) begin miscompares++; $display("FAIL ir_zero got=%h exp=00", ir); end
      end
      vectors++; if (regs !== 32'h44332211) begin miscompares++; $display("FAIL regs_all got=%h exp=44332211", regs); end
      loadIR = 1; dbus = 8'hA5;
      tick();
      vectors++; if (ir !== 8'hA5) begin miscompares++; $display("FAIL ir_load got=%h exp=a5", ir); end
      tick();
      vectors++; if (ir !== 8'h00) begin miscompares++; $display("FAIL ir_clear got=%h exp=00", ir); end
   endtask

   task automatic test_reset_midop();
      loadPC = 1; dbus = 8'h55; tick();
      ret = 1; tick();
      vectors++; if (pc !== 8'h55 || rsFault !== 1'b1) begin miscompares++; $display("FAIL ret_empty pc=%h f=%b exp=55/1", pc, rsFault); end
      call = 1; dbus = 8'h60; tick();
      vectors++; if (pc !== 8'h60 || rsCount !== 3'd1) begin miscompares++; $display("FAIL call1 pc=%h cnt=%0d exp=60/1", pc, rsCount); end
      assertE = 1; carry = 1; aluZero = 1; loadIR = 1; dbus = 8'h9C; tick();
      vectors++; if (ir !== 8'h9C || flagCarry !== 1'b1 || flagZero !== 1'b1) begin miscompares++; $display("FAIL pre_rst ir=%h c=%b z=%b exp=9c/1/1", ir, flagCarry, flagZero); end
      #2 resetB = 1'b0;
      #1;
      vectors++; if (ir !== 8'h00 || pc !== 8'h00 || regs !== 32'h0) begin miscompares++; $display("FAIL async_rst ir=%h pc=%h regs=%h exp=0", ir, pc, regs); end
      vectors++; if (flagCarry !== 1'b0 || flagZero !== 1'b0 || rsCount !== 3'd0 || rsFault !== 1'b0) begin miscompares++; $display("FAIL async_rst_flags c=%b z=%b cnt=%0d f=%b exp=0", flagCarry, flagZero, rsCount, rsFault); end
      incPC = 1; @(posedge clk); #1;
      vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL rst_hold pc=%h exp=00", pc); end
      @(negedge clk);
      resetB = 1'b1;
      for (int i = 0; i < 3; i++) begin incPC = 1; tick(); end
      vectors++; if (pc !== 8'h03) begin miscompares++; $display("FAIL post_rst_inc pc=%h exp=03", pc); end
   endtask

   task automatic test_cond_jump();
      assertE = 1; carry = 1; aluZero = 0; tick();
      vectors++; if (flagCarry !== 1'b1 || flagZero !== 1'b0 || pc !== 8'h03) begin miscompares++; $display("FAIL flags c=%b z=%b pc=%h exp=1/0/03", flagCarry, flagZero, pc); end
      loadPC = 1; jumpCond = 2'b01; dbus = 8'h40; tick();
      vectors++; if (pc !== 8'h40) begin miscompares++; $display("FAIL jc_carry pc=%h exp=40", pc); end
      loadPC = 1; jumpCond = 2'b10; dbus = 8'h80; incPC = 1; tick();
      vectors++; if (pc !== 8'h41) begin miscompares++; $display("FAIL jz_not_taken pc=%h exp=41", pc); end
      loadPC = 1; jumpCond = 2'b11; dbus = 8'h80; tick();
      vectors++; if (pc !== 8'h41) begin miscompares++; $display("FAIL jnc_hold pc=%h exp=41", pc); end
      assertE = 1; carry = 0; aluZero = 1; loadPC = 1; jumpCond = 2'b10; dbus = 8'h70; incPC = 1; tick();
      vectors++; if (pc !== 8'h42 || flagZero !== 1'b1 || flagCarry !== 1'b0) begin miscompares++; $display("FAIL old_flags pc=%h z=%b c=%b exp=42/1/0", pc, flagZero, flagCarry); end
      loadPC = 1; jumpCond = 2'b10; dbus = 8'h70; tick();
      vectors++; if (pc !== 8'h70) begin miscompares++; $display("FAIL jz_taken pc=%h exp=70", pc); end
      loadPC = 1; jumpCond = 2'b11; dbus = 8'h20; tick();
      vectors++; if (pc !== 8'h20) begin miscompares++; $display("FAIL jnc_taken pc=%h exp=20", pc); end
   endtask

   task automatic test_wrap();
      loadPC = 1; dbus = 8'hFF; tick();
      incPC = 1; tick();
      vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL pc_wrap pc=%h exp=00", pc); end
      loadPC = 1; dbus = 8'hFF; tick();
      call = 1; dbus = 8'h30; tick();
      vectors++; if (pc !== 8'h30 || rsCount !== 3'd1) begin miscompares++; $display("FAIL call_ff pc=%h cnt=%0d exp=30/1", pc, rsCount); end
      ret = 1; tick();
      vectors++; if (pc !== 8'h00 || rsCount !== 3'd0 || rsFault !== 1'b0) begin miscompares++; $display("FAIL ret_wrap pc=%h cnt=%0d f=%b exp=00/0/0", pc, rsCount, rsFault); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_pc [4];
      exp_pc[0] = 8'h41; exp_pc[1] = 8'h31; exp_pc[2] = 8'h21; exp_pc[3] = 8'h11;
      loadPC = 1; dbus = 8'h10; tick();
      for (int i = 0; i < 4; i++) begin
         call = 1; dbus = 8'(8'h20 + 8'h10 * i); tick();
      end
      vectors++; if (pc !== 8'h50 || rsCount !== 3'd4 || rsFault !== 1'b0) begin miscompares++; $display("FAIL stack_full pc=%h cnt=%0d f=%b exp=50/4/0", pc, rsCount, rsFault); end
      call = 1; dbus = 8'h90; tick();
      vectors++; if (pc !== 8'h90 || rsCount !== 3'd4 || rsFault !== 1'b1) begin miscompares++; $display("FAIL overflow pc=%h cnt=%0d f=%b exp=90/4/1", pc, rsCount, rsFault); end
      for (int i = 0; i < 4; i++) begin
         ret = 1; tick();
         vectors++; if (pc !== exp_pc[i] || rsCount !== 3'(3 - i)) begin miscompares++; $display("FAIL ret_%0d pc=%h cnt=%0d exp=%h/%0d", i, pc, rsCount, exp_pc[i], 3 - i); end
      end
      ret = 1; tick();
      vectors++; if (pc !== 8'h11 || rsCount !== 3'd0 || rsFault !== 1'b1) begin miscompares++; $display("FAIL underflow pc=%h cnt=%0d f=%b exp=11/0/1", pc, rsCount, rsFault); end
   endtask

   task automatic test_conflict();
      #2 resetB = 1'b0;
      #1;
      vectors++; if (rsFault !== 1'b0) begin miscompares++; $display("FAIL fault_clear got=%b exp=0", rsFault); end
      @(negedge clk);
      resetB = 1'b1;
      call = 1; dbus = 8'h80; tick();
      call = 1; ret = 1; dbus = 8'h33; tick();
      vectors++; if (pc !== 8'h80 || rsCount !== 3'd1 || rsFault !== 1'b1) begin miscompares++; $display("FAIL conflict pc=%h cnt=%0d f=%b exp=80/1/1", pc, rsCount, rsFault); end
      incPC = 1; tick();
      vectors++; if (rsFault !== 1'b1 || pc !== 8'h81) begin miscompares++; $display("FAIL sticky f=%b pc=%h exp=1/81", rsFault, pc); end
      ret = 1; tick();
      vectors++; if (pc !== 8'h01 || rsCount !== 3'd0) begin miscompares++; $display("FAIL stack_intact pc=%h cnt=%0d exp=01/0", pc, rsCount); end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_reset_midop();
      test_cond_jump();
      test_wrap();
      test_back_to_back();
      test_conflict();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
